// File: rtl/acs_surv_if.sv
// ---------------------------------------------------------------------------
// acs_surv_if
// Bundles the symbol handshake and the traceback-side bus of the
// add-compare-select / survivor store block.
//
// Signals:
//   sym_valid      upstream -> block   received symbol valid
//   sym_in[1:0]    upstream -> block   received symbol {c0,c1}
//   sym_ready      block -> upstream   block accepts a symbol this cycle
//   tb_done        traceback -> block  traceback finished with the block
//   en_tbck        block -> traceback  traceback enable
//   bck_prv_st_xx  block -> traceback  survivor predecessor of state xx
//   sel_node       block -> traceback  traceback start state
//   pm_min         block -> traceback  final metric of sel_node
//   busy           block -> anyone     block in progress
//
// Modports: master = upstream/traceback side, slave = acs_surv.
// ---------------------------------------------------------------------------
interface acs_surv_if #(
    parameter int PM_W = 8
);
    logic            sym_valid;
    logic [1:0]      sym_in;
    logic            sym_ready;
    logic            tb_done;
    logic            en_tbck;
    logic [1:0]      bck_prv_st_00;
    logic [1:0]      bck_prv_st_01;
    logic [1:0]      bck_prv_st_10;
    logic [1:0]      bck_prv_st_11;
    logic [1:0]      sel_node;
    logic [PM_W-1:0] pm_min;
    logic            busy;

    modport master (
        output sym_valid,
        output sym_in,
        output tb_done,
        input  sym_ready,
        input  en_tbck,
        input  bck_prv_st_00,
        input  bck_prv_st_01,
        input  bck_prv_st_10,
        input  bck_prv_st_11,
        input  sel_node,
        input  pm_min,
        input  busy
    );

    modport slave (
        input  sym_valid,
        input  sym_in,
        input  tb_done,
        output sym_ready,
        output en_tbck,
        output bck_prv_st_00,
        output bck_prv_st_01,
        output bck_prv_st_10,
        output bck_prv_st_11,
        output sel_node,
        output pm_min,
        output busy
    );
endinterface

// File: rtl/acs_surv.sv
// ---------------------------------------------------------------------------
// acs_surv
// Add-compare-select and survivor store for the K=3, rate-1/2, (7,5)-octal
// 4-state Viterbi decoder. Collects TB_LEN symbols per block, keeping path
// metrics and one survivor row per symbol, then streams the rows
// newest-first to the traceback decoder together with the best end state.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   acs_surv_if.slave: symbol handshake in, traceback bus out
//
// State encoding: s = {s1,s0}, s1 = newest input bit; input u moves s to
// {u,s1}. Code bits from state s with input u: c0 = u^s1^s0, c1 = u^s0.
// All outputs are registered.
// ---------------------------------------------------------------------------
module acs_surv #(
    parameter int TB_LEN = 8,
    parameter int PM_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    acs_surv_if.slave  bus
);

    localparam int CNT_W = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TB_LEN - 1);
    localparam logic [CNT_W-1:0] ZERO_IDX = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);
    localparam logic [PM_W-1:0]  PM_ZERO  = {PM_W{1'b0}};
    localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACS  = 2'd1,
        ST_TBCK = 2'd2
    } state_t;

    // Hamming distance between the received symbol and the code bits the
    // encoder emits when leaving state pred with input u.
    function automatic logic [1:0] branch_metric(
        input logic [1:0] sym,
        input logic [1:0] pred,
        input logic       u
    );
        logic c0;
        logic c1;
        c0 = u ^ pred[1] ^ pred[0];
        c1 = u ^ pred[0];
        return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
    endfunction

    // Saturating add of a branch metric onto a path metric.
    function automatic logic [PM_W-1:0] sat_add(
        input logic [PM_W-1:0] a,
        input logic [1:0]      b
    );
        logic [PM_W:0] sum;
        sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        if (sum[PM_W]) begin
            return PM_MAX;
        end else begin
            return sum[PM_W-1:0];
        end
    endfunction

    // Registers
    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            r_q, r_d;
    logic [3:0][PM_W-1:0]        pm_q, pm_d;
    logic [7:0]                  rows_q [TB_LEN];
    logic [1:0]                  sel_q, sel_d;
    logic [PM_W-1:0]             pm_min_q, pm_min_d;
    logic                        en_q, en_d;
    logic [7:0]                  bck_q, bck_d;
    logic                        ready_q, ready_d;
    logic                        busy_q, busy_d;

    // Combinational helpers
    logic                        accept_s;
    logic                        last_s;
    logic [3:0][PM_W-1:0]        pm_src_s;
    logic [3:0][PM_W-1:0]        pm_new_s;
    logic [7:0]                  row_new_s;
    logic [CNT_W-1:0]            wr_idx_s;
    logic [1:0]                  best_idx_s;
    logic [PM_W-1:0]             best_pm_s;

    // ready_q always mirrors "state is not TBCK", so it doubles as the accept gate.
    assign accept_s = bus.sym_valid & ready_q;
    assign last_s   = (state_q == ST_ACS) && (cnt_q == LAST_IDX);
    assign wr_idx_s = (state_q == ST_IDLE) ? ZERO_IDX : cnt_q;

    // Add-compare-select: new metrics and survivor row for the current symbol.
    always_comb begin
        pm_src_s  = pm_q;
        pm_new_s  = pm_q;
        row_new_s = 8'h00;
        // A block always starts from the known encoder state 00.
        if (state_q == ST_IDLE) begin
            pm_src_s[0] = PM_ZERO;
            pm_src_s[1] = PM_MAX;
            pm_src_s[2] = PM_MAX;
            pm_src_s[3] = PM_MAX;
        end else begin
            pm_src_s = pm_q;
        end
        for (int ns = 0; ns < 4; ns++) begin
            logic [1:0]      ns_v;
            logic [1:0]      p0;
            logic [1:0]      p1;
            logic [PM_W-1:0] cand0;
            logic [PM_W-1:0] cand1;
            ns_v  = 2'(ns);
            p0    = {ns_v[0], 1'b0};
            p1    = {ns_v[0], 1'b1};
            cand0 = sat_add(pm_src_s[p0], branch_metric(bus.sym_in, p0, ns_v[1]));
            cand1 = sat_add(pm_src_s[p1], branch_metric(bus.sym_in, p1, ns_v[1]));
            // Strict compare: a tie keeps the predecessor with s0=0.
            if (cand1 < cand0) begin
                pm_new_s[ns]        = cand1;
                row_new_s[2*ns +: 2] = p1;
            end else begin
                pm_new_s[ns]        = cand0;
                row_new_s[2*ns +: 2] = p0;
            end
        end
    end

    // Best end state among the freshly computed metrics, lowest index on tie.
    always_comb begin
        best_idx_s = 2'd0;
        best_pm_s  = pm_new_s[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_new_s[i] < best_pm_s) begin
                best_idx_s = 2'(i);
                best_pm_s  = pm_new_s[i];
            end else begin
                best_idx_s = best_idx_s;
                best_pm_s  = best_pm_s;
            end
        end
    end

    // Next-state logic of the block FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ACS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACS: begin
                if (accept_s && last_s) begin
                    state_d = ST_TBCK;
                end else begin
                    state_d = ST_ACS;
                end
            end
            ST_TBCK: begin
                if (bus.tb_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TBCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of counters, metrics, results and registered outputs.
    always_comb begin
        cnt_d    = cnt_q;
        r_d      = r_q;
        pm_d     = pm_q;
        sel_d    = sel_q;
        pm_min_d = pm_min_q;

        if (accept_s) begin
            pm_d = pm_new_s;
            if (state_q == ST_IDLE) begin
                cnt_d = ONE_IDX;
            end else if (last_s) begin
                cnt_d    = ZERO_IDX;
                r_d      = LAST_IDX;
                sel_d    = best_idx_s;
                pm_min_d = best_pm_s;
            end else begin
                cnt_d = cnt_q + ONE_IDX;
            end
        end else if (state_q == ST_TBCK) begin
            // Walk rows newest-first, then park on row 0 until tb_done.
            if (r_q != ZERO_IDX) begin
                r_d = r_q - ONE_IDX;
            end else begin
                r_d = ZERO_IDX;
            end
        end else begin
            r_d = r_q;
        end

        en_d = (state_q == ST_TBCK) && !bus.tb_done;
        if (en_d) begin
            bck_d = rows_q[r_q];
        end else begin
            bck_d = 8'h00;
        end

        ready_d = (state_d != ST_TBCK);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= ZERO_IDX;
            r_q      <= ZERO_IDX;
            pm_q[0]  <= PM_ZERO;
            pm_q[1]  <= PM_MAX;
            pm_q[2]  <= PM_MAX;
            pm_q[3]  <= PM_MAX;
            sel_q    <= 2'd0;
            pm_min_q <= PM_ZERO;
            en_q     <= 1'b0;
            bck_q    <= 8'h00;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            pm_q     <= pm_d;
            sel_q    <= sel_d;
            pm_min_q <= pm_min_d;
            en_q     <= en_d;
            bck_q    <= bck_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Survivor row store, one row written per accepted symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TB_LEN; k++) begin
                rows_q[k] <= 8'h00;
            end
        end else if (accept_s) begin
            rows_q[wr_idx_s] <= row_new_s;
        end else begin
            rows_q[wr_idx_s] <= rows_q[wr_idx_s];
        end
    end

    assign bus.sym_ready     = ready_q;
    assign bus.en_tbck       = en_q;
    assign bus.bck_prv_st_00 = bck_q[1:0];
    assign bus.bck_prv_st_01 = bck_q[3:2];
    assign bus.bck_prv_st_10 = bck_q[5:4];
    assign bus.bck_prv_st_11 = bck_q[7:6];
    assign bus.sel_node      = sel_q;
    assign bus.pm_min        = pm_min_q;
    assign bus.busy          = busy_q;

endmodule
